// File: rtl/wb_mailbox_pkg.sv
// Shared constants for wb_mailbox: register offsets, mailbox codes,
// STATUS bit positions and small decode helpers.
package wb_mailbox_pkg;

  localparam logic [3:0] ADR_MAILBOX = 4'h0;
  localparam logic [3:0] ADR_TXDATA  = 4'h4;
  localparam logic [3:0] ADR_STATUS  = 4'h8;
  localparam logic [3:0] ADR_CYCLE   = 4'hC;

  localparam logic [7:0] PASS_CODE = 8'h01;
  localparam logic [7:0] FAIL_CODE = 8'hFF;

  localparam int unsigned ST_DONE    = 0;
  localparam int unsigned ST_PASS    = 1;
  localparam int unsigned ST_FULL    = 2;
  localparam int unsigned ST_EMPTY   = 3;
  localparam int unsigned ST_TIMEOUT = 4;
  localparam int unsigned ST_OCC_LSB = 8;

  typedef enum logic [2:0] {
    REG_MAILBOX,
    REG_TXDATA,
    REG_STATUS,
    REG_CYCLE,
    REG_NONE
  } reg_e;

  // Misaligned or unmapped offsets all collapse to REG_NONE.
  function automatic reg_e decode_reg(input logic [3:0] adr);
    case (adr)
      ADR_MAILBOX: return REG_MAILBOX;
      ADR_TXDATA:  return REG_TXDATA;
      ADR_STATUS:  return REG_STATUS;
      ADR_CYCLE:   return REG_CYCLE;
      default:     return REG_NONE;
    endcase
  endfunction

  function automatic logic [7:0] sat_u8(input int unsigned v);
    return (v > 32'd255) ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; no read bypass, DEPTH must be a
// power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_mailbox.sv
// Wishbone B4 pipelined test-termination mailbox with console byte FIFO.
// Optional: define WB_MAILBOX_TIMEOUT_EN to fail the test at MAX_CYCLES.
module wb_mailbox
  import wb_mailbox_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned MAX_CYCLES = 200_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        done,
  output logic        pass,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_CYCLES == 0) begin : g_bad_param
    $error("wb_mailbox: illegal FIFO_DEPTH or MAX_CYCLES");
  end

  reg_e          reg_sel;
  logic          accept;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic          mbox_wr;
  logic [31:0]   status_word;
  logic [31:0]   rdata;
  logic [31:0]   cycle_q;
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          done_q;
  logic          pass_q;
  logic [7:0]    mbox_q;
  logic          timeout_q;
  logic          unused_ok;

  assign unused_ok = ^{wb_sel_i[3:1], wb_dat_i[31:8]};

  assign reg_sel    = decode_reg(wb_adr_i);
  assign wb_stall_o = wb_cyc_i && wb_stb_i && wb_we_i && wb_sel_i[0] &&
                      (reg_sel == REG_TXDATA) && fifo_full;
  assign accept     = wb_cyc_i && wb_stb_i && !wb_stall_o;
  assign fifo_push  = accept && wb_we_i && wb_sel_i[0] && (reg_sel == REG_TXDATA);
  assign mbox_wr    = accept && wb_we_i && wb_sel_i[0] && (reg_sel == REG_MAILBOX);
  assign fifo_pop   = !fifo_empty && tx_ready;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (wb_dat_i[7:0]),
    .pop   (fifo_pop),
    .dout  (tx_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tx_valid = !fifo_empty;

  always_comb begin
    status_word                   = '0;
    status_word[ST_DONE]          = done_q;
    status_word[ST_PASS]          = pass_q;
    status_word[ST_FULL]          = fifo_full;
    status_word[ST_EMPTY]         = fifo_empty;
    status_word[ST_TIMEOUT]       = timeout_q;
    status_word[ST_OCC_LSB +: 8]  = sat_u8(32'(fifo_count));
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_MAILBOX: rdata = {24'h0, mbox_q};
      REG_STATUS:  rdata = status_word;
      REG_CYCLE:   rdata = cycle_q;
      default:     rdata = '0;
    endcase
  end

`ifdef WB_MAILBOX_TIMEOUT_EN
  localparam logic [31:0] MAX_CYCLES_W = 32'(MAX_CYCLES);
`else
  assign timeout_q = 1'b0;
`endif

  // Timeout is evaluated after the mailbox write so it wins a same-cycle tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_q <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      mbox_q  <= '0;
`ifdef WB_MAILBOX_TIMEOUT_EN
      timeout_q <= 1'b0;
`endif
    end else begin
      cycle_q <= cycle_q + 32'd1;
      ack_q   <= accept;
      dat_q   <= (accept && !wb_we_i) ? rdata : '0;
      if (mbox_wr && !done_q) begin
        mbox_q <= wb_dat_i[7:0];
        if (wb_dat_i[7:0] == PASS_CODE) begin
          done_q <= 1'b1;
          pass_q <= 1'b1;
        end else if (wb_dat_i[7:0] == FAIL_CODE) begin
          done_q <= 1'b1;
          pass_q <= 1'b0;
        end
      end
`ifdef WB_MAILBOX_TIMEOUT_EN
      if (!done_q && cycle_q == MAX_CYCLES_W) begin
        done_q    <= 1'b1;
        pass_q    <= 1'b0;
        timeout_q <= 1'b1;
      end
`endif
    end
  end

  assign wb_ack_o = ack_q && wb_cyc_i;
  assign wb_dat_o = wb_ack_o ? dat_q : '0;
  assign done     = done_q;
  assign pass     = pass_q;

endmodule

// File: tb/tb_wb_mailbox.sv
// Self-checking bench for wb_mailbox against a queue-based reference model.
// Define WB_MAILBOX_TIMEOUT_EN to also exercise the timeout path.
module tb_wb_mailbox;

  localparam int DEPTH = 16;
`ifdef WB_MAILBOX_TIMEOUT_EN
  localparam int MAXC = 100;
`else
  localparam int MAXC = 200000;
`endif

  logic        clk;
  logic        rst_n;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [3:0]  wb_adr_i, wb_sel_i;
  logic [31:0] wb_dat_i;
  logic        wb_stall_o, wb_ack_o;
  logic [31:0] wb_dat_o;
  logic        done, pass;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  wb_mailbox #(
    .FIFO_DEPTH (DEPTH),
    .MAX_CYCLES (MAXC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_cyc_i   (wb_cyc_i),
    .wb_stb_i   (wb_stb_i),
    .wb_we_i    (wb_we_i),
    .wb_adr_i   (wb_adr_i),
    .wb_sel_i   (wb_sel_i),
    .wb_dat_i   (wb_dat_i),
    .wb_stall_o (wb_stall_o),
    .wb_ack_o   (wb_ack_o),
    .wb_dat_o   (wb_dat_o),
    .done       (done),
    .pass       (pass),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  q[$];
  logic        m_done, m_pass, m_to;
  logic [7:0]  m_mbox;
  logic [31:0] m_cyc;
  logic        pend_acc;
  logic [31:0] pend_dat;

  // Per-cycle expectations produced by settle()
  logic        e_ack, e_stall, e_valid;
  logic [31:0] e_dat;
  logic [7:0]  e_data;
  logic        s_acc, s_push, s_pop;
  logic [31:0] s_rd;

  task automatic drive(input logic cyc, input logic stb, input logic we,
                       input logic [3:0] adr, input logic [3:0] sel, input logic [31:0] dat);
    wb_cyc_i = cyc; wb_stb_i = stb; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
  endtask

  task automatic model_reset();
    q.delete();
    m_done = 0; m_pass = 0; m_to = 0; m_mbox = 8'h00; m_cyc = 32'd0;
    pend_acc = 0; pend_dat = 32'd0;
  endtask

  // Called at a falling edge after inputs are set; computes what the DUT should show now.
  task automatic settle();
    int n;
    logic [7:0] occ;
    #1;
    n       = q.size();
    occ     = (n > 255) ? 8'hFF : 8'(n);
    e_ack   = pend_acc && wb_cyc_i;
    e_dat   = e_ack ? pend_dat : 32'd0;
    e_stall = wb_cyc_i && wb_stb_i && wb_we_i && wb_sel_i[0] && wb_adr_i == 4'h4 && n == DEPTH;
    e_valid = (n != 0);
    e_data  = (n != 0) ? q[0] : 8'h00;
    s_acc   = wb_cyc_i && wb_stb_i && !e_stall;
    s_push  = s_acc && wb_we_i && wb_sel_i[0] && wb_adr_i == 4'h4;
    s_pop   = (n != 0) && tx_ready;
    s_rd    = 32'd0;
    if (s_acc && !wb_we_i) begin
      case (wb_adr_i)
        4'h0: s_rd = {24'd0, m_mbox};
        4'h8: s_rd = {16'd0, occ, 3'd0, m_to, n == 0, n == DEPTH, m_pass, m_done};
        4'hC: s_rd = m_cyc;
        default: s_rd = 32'd0;
      endcase
    end
  endtask

  // Applies the rising-edge effects to the model and moves to the next falling edge.
  task automatic advance();
    logic old_done;
    old_done = m_done;
    if (s_acc && wb_we_i && wb_adr_i == 4'h0 && wb_sel_i[0] && !m_done) begin
      m_mbox = wb_dat_i[7:0];
      if (wb_dat_i[7:0] == 8'h01) begin m_done = 1; m_pass = 1; end
      else if (wb_dat_i[7:0] == 8'hFF) begin m_done = 1; m_pass = 0; end
    end
    if (s_pop) void'(q.pop_front());
    if (s_push) q.push_back(wb_dat_i[7:0]);
`ifdef WB_MAILBOX_TIMEOUT_EN
    if (!old_done && m_cyc == 32'(MAXC)) begin m_done = 1; m_pass = 0; m_to = 1; end
`else
    if (old_done && !m_done) m_done = 1;
`endif
    m_cyc    = m_cyc + 32'd1;
    pend_acc = s_acc;
    pend_dat = s_rd;
    @(negedge clk);
  endtask

  // Asserts reset with cyc held high so a cleared ack is due to reset alone.
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack got=%0b exp=0", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL rst_dat got=%h exp=0", wb_dat_o); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL rst_txvalid got=%0b exp=0", tx_valid); end
    checks++; if ({done, pass} !== 2'b00) begin errors++; $display("FAIL rst_donepass got=%b exp=00", {done, pass}); end
    checks++; if (wb_stall_o !== 1'b0) begin errors++; $display("FAIL rst_stall got=%0b exp=0", wb_stall_o); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    drive(1, 1, 0, 4'h8, 4'hF, 32'd0);
    settle();
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL reset_status_ack got=%0b exp=1", wb_ack_o); end
    checks++; if (wb_dat_o !== 32'h0000_0008) begin errors++; $display("FAIL reset_status got=%h exp=00000008", wb_dat_o); end
    advance();
  endtask

  task automatic test_mailbox_pass();
    do_reset();
    drive(1, 1, 1, 4'h0, 4'h1, 32'h0000_0001);
    settle();
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL pass_ack got=%0b exp=1", wb_ack_o); end
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL pass_donepass got=%b exp=11", {done, pass}); end
    advance();
    drive(1, 1, 1, 4'h0, 4'h1, 32'h0000_00FF);
    settle();
    advance();
    drive(1, 1, 0, 4'h0, 4'hF, 32'd0);
    settle();
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL pass_sticky got=%b exp=11", {done, pass}); end
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_dat_o !== 32'h0000_0001) begin errors++; $display("FAIL pass_mbox_read got=%h exp=00000001", wb_dat_o); end
    advance();
  endtask

  task automatic test_mailbox_fail();
    do_reset();
    drive(1, 1, 1, 4'h0, 4'h1, 32'h0000_00FF);
    settle();
    advance();
    drive(1, 1, 0, 4'h8, 4'hF, 32'd0);
    settle();
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL fail_donepass got=%b exp=10", {done, pass}); end
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_dat_o !== 32'h0000_0009) begin errors++; $display("FAIL fail_status got=%h exp=00000009", wb_dat_o); end
    advance();
  endtask

  task automatic test_unmapped();
    do_reset();
    drive(1, 1, 1, 4'h2, 4'hF, 32'h0000_0001);
    settle();
    advance();
    drive(1, 1, 1, 4'h8, 4'hF, 32'hFFFF_FFFF);
    settle();
    checks++; if (wb_ack_o !== 1'b1) begin errors++; $display("FAIL unmapped_wr_ack got=%0b exp=1", wb_ack_o); end
    advance();
    drive(1, 1, 1, 4'h4, 4'hE, 32'h0000_0055);
    settle();
    advance();
    drive(1, 1, 0, 4'h6, 4'hF, 32'd0);
    settle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL unmapped_done got=%0b exp=0", done); end
    checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL nosel_push got=%0b exp=0", tx_valid); end
    advance();
    drive(1, 1, 0, 4'h4, 4'hF, 32'd0);
    settle();
    checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== 32'd0) begin errors++; $display("FAIL unmapped_read ack=%0b dat=%h exp ack=1 dat=0", wb_ack_o, wb_dat_o); end
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL txdata_read got=%h exp=0", wb_dat_o); end
    advance();
  endtask

  task automatic test_fifo_stall();
    int acks;
    bit drained;
    do_reset();
    tx_ready = 1'b0;
    acks = 0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 1, 1, 4'h4, 4'h1, $urandom);
      settle();
      if (wb_ack_o) acks++;
      checks++; if (wb_stall_o !== (i == 16)) begin errors++; $display("FAIL fill_stall[%0d] got=%0b exp=%0b", i, wb_stall_o, i == 16); end
      advance();
    end
    checks++; if (acks != 16) begin errors++; $display("FAIL fill_acks got=%0d exp=16", acks); end
    tx_ready = 1'b1;
    settle();
    if (wb_ack_o) acks++;
    checks++; if (wb_stall_o !== 1'b1) begin errors++; $display("FAIL full_pop_stall got=%0b exp=1", wb_stall_o); end
    checks++; if (tx_valid !== e_valid || tx_data !== e_data) begin errors++; $display("FAIL full_head got=%0b/%h exp=%0b/%h", tx_valid, tx_data, e_valid, e_data); end
    advance();
    tx_ready = 1'b0;
    settle();
    if (wb_ack_o) acks++;
    checks++; if (wb_stall_o !== 1'b0) begin errors++; $display("FAIL after_pop_stall got=%0b exp=0", wb_stall_o); end
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    if (wb_ack_o) acks++;
    checks++; if (acks != 17) begin errors++; $display("FAIL total_acks got=%0d exp=17", acks); end
    advance();
    tx_ready = 1'b1;
    drained = 0;
    for (int c = 0; c < 40 && !drained; c++) begin
      settle();
      checks++; if (tx_valid !== e_valid || (e_valid && tx_data !== e_data)) begin
        errors++; $display("FAIL drain_byte got=%0b/%h exp=%0b/%h", tx_valid, tx_data, e_valid, e_data);
      end
      if (!e_valid) drained = 1;
      else advance();
    end
    checks++; if (!drained) begin errors++; $display("FAIL drain_timeout left=%0d exp=0", q.size()); end
    advance();
    tx_ready = 1'b0;
  endtask

  task automatic test_cycle();
    logic [31:0] prev;
    prev = 32'd0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1, 1, 0, 4'hC, 4'hF, 32'd0);
      else drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
      settle();
      if (i > 0) begin
        checks++; if (wb_ack_o !== 1'b1 || wb_dat_o !== e_dat) begin errors++; $display("FAIL cycle_read[%0d] got=%h exp=%h", i, wb_dat_o, e_dat); end
      end
      if (i > 1) begin
        checks++; if (wb_dat_o !== prev + 32'd1) begin errors++; $display("FAIL cycle_step[%0d] got=%h exp=%h", i, wb_dat_o, prev + 32'd1); end
      end
      prev = wb_dat_o;
      advance();
    end
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cyc = 32'hFFFF_FFFF;
    drive(1, 1, 0, 4'hC, 4'hF, 32'd0);
    settle();
    advance();
    settle();
    checks++; if (wb_dat_o !== 32'hFFFF_FFFF) begin errors++; $display("FAIL cycle_max got=%h exp=ffffffff", wb_dat_o); end
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL cycle_wrap got=%h exp=00000000", wb_dat_o); end
    advance();
  endtask

  task automatic test_cyc_drop_and_reset();
    do_reset();
    drive(1, 1, 1, 4'h0, 4'h1, 32'h0000_0001);
    settle();
    advance();
    drive(0, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL drop_ack got=%0b exp=0", wb_ack_o); end
    checks++; if ({done, pass} !== 2'b11) begin errors++; $display("FAIL drop_effect got=%b exp=11", {done, pass}); end
    advance();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 4'h4, 4'h1, $urandom);
      settle();
      advance();
    end
    settle();
    checks++; if (wb_ack_o !== 1'b1 || tx_valid !== 1'b1) begin errors++; $display("FAIL preburst ack=%0b valid=%0b exp=1/1", wb_ack_o, tx_valid); end
    do_reset();
  endtask

  task automatic test_random();
    int r;
    do_reset();
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 5);
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
            (r == 0) ? 4'h0 : (r < 3) ? 4'h4 : (r == 3) ? 4'h8 : (r == 4) ? 4'hC : 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), $urandom);
      if (wb_adr_i == 4'h0 && i > 250 && $urandom_range(0, 3) == 0)
        wb_dat_i[7:0] = $urandom_range(0, 1) ? 8'h01 : 8'hFF;
      tx_ready = $urandom_range(0, 9) < 3;
      settle();
      checks++; if (wb_ack_o !== e_ack || wb_dat_o !== e_dat) begin errors++; $display("FAIL rnd_ack[%0d] got=%0b/%h exp=%0b/%h", i, wb_ack_o, wb_dat_o, e_ack, e_dat); end
      checks++; if (wb_stall_o !== e_stall) begin errors++; $display("FAIL rnd_stall[%0d] got=%0b exp=%0b", i, wb_stall_o, e_stall); end
      checks++; if (tx_valid !== e_valid || (e_valid && tx_data !== e_data)) begin errors++; $display("FAIL rnd_tx[%0d] got=%0b/%h exp=%0b/%h", i, tx_valid, tx_data, e_valid, e_data); end
      checks++; if ({done, pass} !== {m_done, m_pass}) begin errors++; $display("FAIL rnd_donepass[%0d] got=%b exp=%b", i, {done, pass}, {m_done, m_pass}); end
      advance();
    end
    tx_ready = 1'b0;
  endtask

`ifdef WB_MAILBOX_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    for (int i = 0; i < 100; i++) begin
      settle();
      advance();
    end
    settle();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL timeout_early got=%0b exp=0", done); end
    advance();
    drive(1, 1, 0, 4'h8, 4'hF, 32'd0);
    settle();
    checks++; if ({done, pass} !== 2'b10) begin errors++; $display("FAIL timeout_donepass got=%b exp=10", {done, pass}); end
    advance();
    drive(1, 0, 0, 4'h0, 4'h0, 32'd0);
    settle();
    checks++; if (wb_dat_o[4] !== 1'b1 || wb_dat_o !== e_dat) begin errors++; $display("FAIL timeout_status got=%h exp=%h", wb_dat_o, e_dat); end
    advance();
  endtask
`endif

  initial begin
    rst_n = 1'b1;
    tx_ready = 1'b0;
    drive(0, 0, 0, 4'h0, 4'h0, 32'd0);
    model_reset();
    @(negedge clk);
    test_reset();
    test_mailbox_pass();
    test_mailbox_fail();
    test_unmapped();
    test_fifo_stall();
    test_cycle();
    test_cyc_drop_and_reset();
    test_random();
`ifdef WB_MAILBOX_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
